rect_plotter: RTL and testbench
===============================

Name: rect_plotter

Overview:
- Drawing engine that produces the pixel-write stream consumed by the 160x120 VGA framebuffer adapter (x, y, colour, plot).
- Accepts one filled-rectangle command at a time over a valid/ready handshake.
- Emits one pixel write per clock in row-major order and clips pixels that fall off-screen.
- Sits between game logic (paddles, ball, score blocks) and the VGA adapter, so game logic issues whole rectangles instead of individual pixels.

Parameters:
- X_W, 8, width of x coordinate and rectangle width.
- Y_W, 7, width of y coordinate and rectangle height.
- COLOUR_W, 3, colour width (1 bit per channel).
- X_MAX, 159, last visible column.
- Y_MAX, 119, last visible row.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  reset; one clock; reset is synchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_x  in  X_W  top-left column.
- cmd_y  in  Y_W  top-left row.
- cmd_w  in  X_W  width in pixels; 0 means empty.
- cmd_h  in  Y_W  height in pixels; 0 means empty.
- cmd_colour  in  COLOUR_W  fill colour.
- x  out  X_W  pixel column to the adapter.
- y  out  Y_W  pixel row to the adapter.
- colour  out  COLOUR_W  pixel colour to the adapter.
- plot  out  1  write strobe to the adapter.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, DRAW, DONE.
  - cmd_ready is 1 only in IDLE.
  - busy is 1 in DRAW and DONE.
- Reset (resetn low at an edge): state goes to IDLE; x=0, y=0, colour=0, plot=0, done=0. cmd_valid is ignored while resetn is low.
- Handshake: the command is accepted at an edge where state is IDLE and cmd_valid=1. All cmd_* fields are latched at that edge; later changes to them have no effect.
- Zero-area command (cmd_w==0 or cmd_h==0): IDLE goes to DONE; no plot is ever asserted.
- Otherwise IDLE goes to DRAW.
- Output registers:
  - x, y, colour and plot are registered.
  - Pixel n (n = 0 .. w*h-1) appears in the cycle after edge k+n, where k is the accept edge. This gives 1-cycle latency and one pixel per cycle with no gaps.
- Scan order: column offset dx runs 0..w-1 fastest, then row offset dy runs 0..h-1.
  - Pixel coordinates are (cmd_x+dx, cmd_y+dy).
  - Sums are computed X_W+1 / Y_W+1 bits wide.
- Clipping: if the full-width sum exceeds X_MAX or Y_MAX, plot=0 for that cycle but the cycle is still consumed. x and y are don't-care whenever plot=0. The cycle count is therefore always w*h.
- After the last pixel, DRAW goes to DONE.
  - DONE lasts exactly 1 cycle with done=1 and plot=0, then goes to IDLE.
  - A new command can be accepted at the first edge back in IDLE.
- colour is held at the latched cmd_colour throughout DRAW.
- In IDLE and DONE: plot=0, and x, y, colour hold their last values.
- Reset mid-operation: aborts at the reset edge; plot=0 from the next cycle; no done pulse.

Optional Feature:
- Macro: RECT_PLOTTER_CLEAR_EN.
- When defined:
  - Adds input port clear_req (1 bit).
  - In IDLE, clear_req=1 takes priority over cmd_valid. cmd_ready is 0 in any cycle where clear_req=1.
  - The engine fills (0,0)..(X_MAX,Y_MAX) with colour 0: (X_MAX+1)*(Y_MAX+1) = 19200 plot cycles, row-major, no clipping.
  - Then DONE for 1 cycle with done=1.
- When undefined: no clear_req port; the behaviour is exactly as above.

Test Plan:
1. Hold resetn=0 for 2 cycles, then release -> plot=0, done=0, busy=0, x=0, y=0, colour=0, cmd_ready=1.
2. Command x=10, y=20, w=3, h=2, colour=3'b100 accepted at edge 0 -> plot=1, colour=100 in cycles 1..6 with (10,20), (11,20), (12,20), (10,21), (11,21), (12,21). Then done=1 in cycle 7, cmd_ready=0 in cycles 1..7, cmd_ready=1 in cycle 8.
3. Command x=158, y=119, w=4, h=2 -> 8 DRAW cycles; plot=1 only for (158,119) and (159,119); done in cycle 9.
4. Command w=0, h=5 -> no plot at any time; done=1 in cycle 1; cmd_ready=1 in cycle 2. Repeat with w=5, h=0 -> same response.
5. cmd_valid held high with 1x1 command A, then a 2x1 command B presented after A's accept -> A's plot in cycle 1, A's done in cycle 2, B accepted at edge 3, B's plots in cycles 4..5, B's done in cycle 6.
6. Reset asserted after 3 pixels of a 4x4 draw -> plot=0 after the reset edge, done never pulses, cmd_ready=1 once resetn returns high. With RECT_PLOTTER_CLEAR_EN: clear_req -> exactly 19200 plots with colour 0, last at (159,119), then done.

Source files
------------

// File: rtl/rect_plotter.sv
// Filled-rectangle pixel engine feeding the 160x120 VGA adapter; optional RECT_PLOTTER_CLEAR_EN adds a full-screen clear.
// Latency: first pixel registered one cycle after accept, then one pixel per clock, w*h cycles total, then a 1-cycle done.
// Backpressure: cmd_ready only in IDLE; the adapter cannot stall the pixel stream.
module rect_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119
) (
    input  logic                clock,
    input  logic                resetn,
`ifdef RECT_PLOTTER_CLEAR_EN
    input  logic                clear_req,
`endif
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [X_W-1:0]      cmd_x,
    input  logic [Y_W-1:0]      cmd_y,
    input  logic [X_W-1:0]      cmd_w,
    input  logic [Y_W-1:0]      cmd_h,
    input  logic [COLOUR_W-1:0] cmd_colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [X_W-1:0]      lat_x, lat_w, dx;
    logic [Y_W-1:0]      lat_y, lat_h, dy;

    logic                take_clear;
    logic                accept, empty;
    logic [X_W-1:0]      start_x, start_w, bx, ox;
    logic [Y_W-1:0]      start_y, start_h, by, oy;
    logic [COLOUR_W-1:0] start_colour;
    logic                last_col, last_row;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                in_bounds;

`ifdef RECT_PLOTTER_CLEAR_EN
    assign take_clear = clear_req;
`else
    assign take_clear = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE) && !take_clear;
    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) && (take_clear || cmd_valid);

    // A clear is just a screen-sized rectangle in colour 0, so it reuses the scan path.
    assign start_x      = take_clear ? '0 : cmd_x;
    assign start_y      = take_clear ? '0 : cmd_y;
    assign start_w      = take_clear ? X_W'(X_MAX + 1) : cmd_w;
    assign start_h      = take_clear ? Y_W'(Y_MAX + 1) : cmd_h;
    assign start_colour = take_clear ? '0 : cmd_colour;
    assign empty        = (start_w == '0) || (start_h == '0);

    always_comb begin
        last_col = (dx == lat_w - X_W'(1));
        last_row = (dy == lat_h - Y_W'(1));
        if (state == S_IDLE) begin
            bx = start_x;
            by = start_y;
            ox = '0;
            oy = '0;
        end else begin
            bx = lat_x;
            by = lat_y;
            ox = last_col ? '0 : dx + X_W'(1);
            oy = last_col ? dy + Y_W'(1) : dy;
        end
        // Sums carry one extra bit so off-screen pixels cannot wrap back on screen.
        sum_x     = {1'b0, bx} + {1'b0, ox};
        sum_y     = {1'b0, by} + {1'b0, oy};
        in_bounds = (sum_x <= (X_W+1)'(X_MAX)) && (sum_y <= (Y_W+1)'(Y_MAX));
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= S_IDLE;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            done   <= 1'b0;
            lat_x  <= '0;
            lat_y  <= '0;
            lat_w  <= '0;
            lat_h  <= '0;
            dx     <= '0;
            dy     <= '0;
        end else begin
            plot <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_x <= start_x;
                        lat_y <= start_y;
                        lat_w <= start_w;
                        lat_h <= start_h;
                        dx    <= '0;
                        dy    <= '0;
                        if (empty) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state  <= S_DRAW;
                            colour <= start_colour;
                            x      <= sum_x[X_W-1:0];
                            y      <= sum_y[Y_W-1:0];
                            plot   <= in_bounds;
                        end
                    end
                end
                S_DRAW: begin
                    if (last_col && last_row) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        dx   <= ox;
                        dy   <= oy;
                        x    <= sum_x[X_W-1:0];
                        y    <= sum_y[Y_W-1:0];
                        plot <= in_bounds;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed self-checking bench for rect_plotter; cycle c means the period after the c-th edge from accept.
module tb_rect_plotter;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_x = '0;
    logic [6:0] cmd_y = '0;
    logic [7:0] cmd_w = '0;
    logic [6:0] cmd_h = '0;
    logic [2:0] cmd_colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;
`ifdef RECT_PLOTTER_CLEAR_EN
    logic       clear_req = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    rect_plotter dut (
        .clock      (clock),
        .resetn     (resetn),
`ifdef RECT_PLOTTER_CLEAR_EN
        .clear_req  (clear_req),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one command for exactly one accept edge, then scramble the fields; returns in cycle 1.
    task automatic send(input logic [7:0] cx, input logic [6:0] cy, input logic [7:0] cw,
                        input logic [6:0] ch, input logic [2:0] cc);
        cmd_x = cx; cmd_y = cy; cmd_w = cw; cmd_h = ch; cmd_colour = cc;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_x = 8'hAA; cmd_y = 7'h55; cmd_w = 8'h0F; cmd_h = 7'h0F; cmd_colour = 3'b011;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cmd_valid = 1'b1;
        repeat (2) tick();
        cmd_valid = 1'b0;
        resetn = 1'b1;
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot got %b want 0", plot); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (x !== 8'd0) begin errors++; $display("FAIL reset_x got %0d want 0", x); end
        checks++; if (y !== 7'd0) begin errors++; $display("FAIL reset_y got %0d want 0", y); end
        checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour got %0d want 0", colour); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_basic();
        int ex[6] = '{10, 11, 12, 10, 11, 12};
        int ey[6] = '{20, 20, 20, 21, 21, 21};
        send(8'd10, 7'd20, 8'd3, 7'd2, 3'b100);
        for (int c = 0; c < 6; c++) begin
            checks++; if (plot !== 1'b1) begin errors++; $display("FAIL basic_plot c%0d got %b want 1", c+1, plot); end
            checks++; if (x !== 8'(ex[c]) || y !== 7'(ey[c])) begin errors++; $display("FAIL basic_xy c%0d got (%0d,%0d) want (%0d,%0d)", c+1, x, y, ex[c], ey[c]); end
            checks++; if (colour !== 3'b100) begin errors++; $display("FAIL basic_colour c%0d got %b want 100", c+1, colour); end
            checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_ctl c%0d got ready=%b busy=%b done=%b want 0 1 0", c+1, cmd_ready, busy, done); end
            tick();
        end
        checks++; if (done !== 1'b1 || plot !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_done c7 got done=%b plot=%b ready=%b busy=%b want 1 0 0 1", done, plot, cmd_ready, busy); end
        tick();
        checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0) begin errors++; $display("FAIL basic_idle c8 got ready=%b done=%b busy=%b plot=%b want 1 0 0 0", cmd_ready, done, busy, plot); end
        checks++; if (x !== 8'd12 || y !== 7'd21 || colour !== 3'b100) begin errors++; $display("FAIL basic_hold got (%0d,%0d,%b) want (12,21,100)", x, y, colour); end
    endtask

    task automatic test_clip();
        logic ep[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int   ex[2] = '{158, 159};
        send(8'd158, 7'd119, 8'd4, 7'd2, 3'b010);
        for (int c = 0; c < 8; c++) begin
            checks++; if (plot !== ep[c] || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clip_plot c%0d got plot=%b done=%b busy=%b want %b 0 1", c+1, plot, done, busy, ep[c]); end
            if (c < 2) begin
                checks++; if (x !== 8'(ex[c]) || y !== 7'd119) begin errors++; $display("FAIL clip_xy c%0d got (%0d,%0d) want (%0d,119)", c+1, x, y, ex[c]); end
            end
            tick();
        end
        checks++; if (done !== 1'b1 || plot !== 1'b0) begin errors++; $display("FAIL clip_done c9 got done=%b plot=%b want 1 0", done, plot); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL clip_ready c10 got %b want 1", cmd_ready); end
    endtask

    task automatic test_zero_area();
        logic [7:0] w[2] = '{8'd0, 8'd5};
        logic [6:0] h[2] = '{7'd5, 7'd0};
        for (int i = 0; i < 2; i++) begin
            send(8'd40, 7'd40, w[i], h[i], 3'b111);
            checks++; if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL zero%0d_c1 got done=%b plot=%b busy=%b ready=%b want 1 0 1 0", i, done, plot, busy, cmd_ready); end
            tick();
            checks++; if (cmd_ready !== 1'b1 || plot !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero%0d_c2 got ready=%b plot=%b done=%b want 1 0 0", i, cmd_ready, plot, done); end
        end
    endtask

    task automatic test_back_to_back();
        cmd_x = 8'd5; cmd_y = 7'd6; cmd_w = 8'd1; cmd_h = 7'd1; cmd_colour = 3'b001;
        cmd_valid = 1'b1;
        tick();
        cmd_x = 8'd30; cmd_y = 7'd40; cmd_w = 8'd2; cmd_h = 7'd1; cmd_colour = 3'b010;
        checks++; if (plot !== 1'b1 || x !== 8'd5 || y !== 7'd6 || colour !== 3'b001) begin errors++; $display("FAIL b2b_a_pix got plot=%b (%0d,%0d,%b) want 1 (5,6,001)", plot, x, y, colour); end
        tick();
        checks++; if (done !== 1'b1 || plot !== 1'b0) begin errors++; $display("FAIL b2b_a_done got done=%b plot=%b want 1 0", done, plot); end
        tick();
        checks++; if (cmd_ready !== 1'b1 || plot !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got ready=%b plot=%b done=%b want 1 0 0", cmd_ready, plot, done); end
        tick();
        cmd_valid = 1'b0;
        checks++; if (plot !== 1'b1 || x !== 8'd30 || y !== 7'd40 || colour !== 3'b010) begin errors++; $display("FAIL b2b_b_pix0 got plot=%b (%0d,%0d,%b) want 1 (30,40,010)", plot, x, y, colour); end
        tick();
        checks++; if (plot !== 1'b1 || x !== 8'd31 || y !== 7'd40) begin errors++; $display("FAIL b2b_b_pix1 got plot=%b (%0d,%0d) want 1 (31,40)", plot, x, y); end
        tick();
        checks++; if (done !== 1'b1 || plot !== 1'b0) begin errors++; $display("FAIL b2b_b_done got done=%b plot=%b want 1 0", done, plot); end
        tick();
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || plot !== 1'b0) begin errors++; $display("FAIL b2b_end got ready=%b busy=%b plot=%b want 1 0 0", cmd_ready, busy, plot); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        send(8'd0, 7'd0, 8'd4, 7'd4, 3'b111);
        tick();
        tick();
        checks++; if (plot !== 1'b1 || x !== 8'd2 || y !== 7'd0) begin errors++; $display("FAIL mid_pix2 got plot=%b (%0d,%0d) want 1 (2,0)", plot, x, y); end
        resetn = 1'b0;
        tick();
        checks++; if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_abort got plot=%b done=%b busy=%b want 0 0 0", plot, done, busy); end
        cmd_x = 8'd1; cmd_y = 7'd1; cmd_w = 8'd2; cmd_h = 7'd2; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        resetn = 1'b1;
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_ready got ready=%b busy=%b want 1 0", cmd_ready, busy); end
        for (int c = 0; c < 20; c++) begin
            if (done !== 1'b0 || plot !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_quiet got %0d cycles with done/plot high want 0", bad); end
    endtask

`ifdef RECT_PLOTTER_CLEAR_EN
    task automatic test_clear();
        int plots = 0;
        int cyc = 0;
        int bad_col = 0;
        logic [7:0] lx = '0;
        logic [6:0] ly = '0;
        clear_req = 1'b1;
        cmd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got %b want 0", cmd_ready); end
        tick();
        clear_req = 1'b0;
        cmd_valid = 1'b0;
        while (done !== 1'b1 && cyc < 20000) begin
            if (plot === 1'b1) begin
                plots++;
                lx = x;
                ly = y;
                if (colour !== 3'd0) bad_col++;
            end
            cyc++;
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clear_timeout got done=%b after %0d cycles want 1", done, cyc); end
        checks++; if (plots !== 19200 || cyc !== 19200) begin errors++; $display("FAIL clear_count got plots=%0d cycles=%0d want 19200 19200", plots, cyc); end
        checks++; if (lx !== 8'd159 || ly !== 7'd119) begin errors++; $display("FAIL clear_last got (%0d,%0d) want (159,119)", lx, ly); end
        checks++; if (bad_col !== 0) begin errors++; $display("FAIL clear_colour got %0d nonzero want 0", bad_col); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL clear_end got ready=%b want 1", cmd_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_zero_area();
        test_back_to_back();
        test_reset_mid();
`ifdef RECT_PLOTTER_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
